uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/t3maps_uart_pkg.sv | 35 +++
 rtl/uart_rx_sync_2ff.sv | 47 ++++
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t3maps_uart_pkg.sv
// ---------------------------------------------------------------------------
// t3maps_uart_pkg
//
// Constants and types shared by the UART receiver and the planned UART
// transmitter:
//   DEFAULT_CLKS_PER_BIT : 100 MHz clock cycles per bit at 115200 baud
//   DATA_BITS            : payload bits per 8N1 frame
//   uart_state_e         : frame state encoding
//   half_bit_max()       : counter value at which the middle of the start bit
//                          is reached
// ---------------------------------------------------------------------------
package t3maps_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int MIN_CLKS_PER_BIT     = 8;
    localparam int MAX_CLKS_PER_BIT     = 65535;
    localparam int DATA_BITS            = 8;

    // Explicit encodings so that a future transmitter and any debug tooling
    // agree on the numeric state values.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // The start bit is checked half a bit period after the falling edge,
    // which lines all later samples up with the middle of each bit.
    function automatic int half_bit_max(input int clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchronizer for a single asynchronous input bit.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output (two clock cycles of latency)
// RESET_VAL sets the value both flops take during reset, so the output shows
// a known, harmless level until real samples have propagated through.
// ---------------------------------------------------------------------------
module sync_2ff
    import t3maps_uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // The first flop may go metastable; the second gives it a full cycle
    // to resolve before anything downstream looks at the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, LSB first, oversampled by the system clock.
//   clk_100      : 100 MHz system clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   rx_serial    : asynchronous serial line, idle high
//   rx_byte      : last correctly framed byte, held until the next good frame
//   rx_ready     : one-cycle pulse when rx_byte has just been updated
//   rx_frame_err : one-cycle pulse when a stop bit is sampled low
//   rx_busy      : high whenever the receiver is not idle
//
// The line is resynchronized, then a frame FSM times each bit with a sample
// counter: the start bit is confirmed at its middle, and each following bit
// is sampled one full bit period later. Every output comes from a flop, so
// there is no combinational path from rx_serial to any output.
// ---------------------------------------------------------------------------
module uart_rx
    import t3maps_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_100,
    input  logic       Reset_n,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(half_bit_max(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rxs;

    uart_state_e      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       byte_q,    byte_d;
    logic             ready_q,   ready_d;
    logic             ferr_q,    ferr_d;
    logic             busy_q,    busy_d;
    logic             armed_q,   armed_d;
    logic [1:0]       settle_q,  settle_d;

    // The synchronizer resets to 1 so the line reads as idle while the
    // real samples are still working their way through.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk_100),
        .rst_n (Reset_n),
        .d     (rx_serial),
        .q     (rxs)
    );

    // settle_q[1] rises once rxs carries a real sample of the line rather
    // than the synchronizer's reset value. Until then, a high rxs says
    // nothing about the line.
    always_comb begin
        settle_d = {settle_q[0], 1'b1};
    end

    // armed_q records that the line has really been seen idle (high) since
    // the last frame started or since reset. IDLE only starts a frame on a
    // low that follows such a high. This is what stops a frame that was cut
    // off by reset from being picked up again halfway through its data bits.
    always_comb begin
        armed_d = armed_q;
        if (settle_q[1] && rxs) begin
            armed_d = 1'b1;
        end
        if ((state_q == ST_IDLE) && !rxs && armed_q) begin
            armed_d = 1'b0;
        end
    end

    // Frame FSM. The sample counter returns to zero on every state change
    // and on every data-bit sample, so it never has to wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs && armed_q) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                end
            end

            // A line that is high again at mid start bit was only a glitch.
            ST_START: begin
                if (cnt_q == HALF_MAX) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Shift right from the top, so the first (LSB) bit received
            // ends up in bit 0 after eight samples.
            ST_DATA: begin
                if (cnt_q == BIT_MAX) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_MAX) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // The line is held low (break or framing fault). Nothing is
            // accepted until the line goes idle again.
            ST_BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
        end
    end

    assign rx_byte      = byte_q;
    assign rx_ready     = ready_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16. Frames are sent
// bit by bit; each frame expected to complete is pushed to exp_q when it is
// sent, and a monitor records every byte the receiver reports so the test
// tasks can pop and compare them in order.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int C       = 16;
    localparam int LAT_NOM = 2 + C / 2 + 9 * C;

    logic       clk_100;
    logic       Reset_n;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_idx = 0;

    int   ready_cnt   = 0;
    int   err_cnt     = 0;
    int   long_cnt    = 0;
    int   overlap_cnt = 0;
    logic prev_ready  = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk_100      (clk_100),
        .Reset_n      (Reset_n),
        .rx_serial    (rx_serial),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    // Records every reported byte and the pulse statistics, sampled
    // half a cycle away from the active edge.
    always @(negedge clk_100) begin
        if (rx_ready) begin
            got_q.push_back(rx_byte);
            ready_cnt = ready_cnt + 1;
            if (prev_ready) long_cnt = long_cnt + 1;
        end
        if (rx_frame_err) err_cnt = err_cnt + 1;
        if (rx_ready && rx_frame_err) overlap_cnt = overlap_cnt + 1;
        prev_ready = rx_ready;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one frame starting at the current (negedge) time. The stop level
    // is left on the line afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_cycles, input bit expect_ok);
        if (expect_ok) exp_q.push_back(b);
        rx_serial = 1'b0;
        repeat (C) @(negedge clk_100);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (C) @(negedge clk_100);
        end
        rx_serial = stop_val;
        repeat (stop_cycles) @(negedge clk_100);
    endtask

    // Waits, with a cycle budget, for n more bytes than have been consumed.
    task automatic wait_frames(input int n, output bit ok);
        int budget;
        budget = 40 * C;
        ok = 1'b0;
        while (budget > 0) begin
            if (got_q.size() >= rd_idx + n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_100);
            budget--;
        end
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk_100);
        tests_run++;
        if (rx_byte !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_rx_byte: got %h, expected 00", rx_byte);
        end
        tests_run++;
        if (rx_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rx_ready: got %b, expected 0", rx_ready);
        end
        tests_run++;
        if (rx_frame_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_frame_err: got %b, expected 0", rx_frame_err);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rx_busy: got %b, expected 0", rx_busy);
        end
        Reset_n = 1'b1;
        repeat (5) @(negedge clk_100);
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_busy: got %b, expected 0", rx_busy);
        end
    endtask

    task automatic test_single_frame();
        int r0, e0;
        bit ok;
        logic [7:0] e;
        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b1, C, 1'b1);
        repeat (4) @(negedge clk_100);
        wait_frames(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL single_timeout: got %0d bytes, expected 1", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q[rd_idx] !== e) begin
                tests_failed++;
                $display("[TB] FAIL single_byte: got %h, expected %h", got_q[rd_idx], e);
            end
            rd_idx++;
        end
        tests_run++;
        if (ready_cnt - r0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_ready_count: got %0d, expected 1", ready_cnt - r0);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_busy_after: got %b, expected 0", rx_busy);
        end
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("[TB] FAIL single_frame_err: got %0d pulses, expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int r0, e0;
        bit ok;
        logic [7:0] e;
        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(8'hFF, 1'b1, C, 1'b1);
        send_frame(8'h7F, 1'b1, C, 1'b1);
        send_frame(8'h7E, 1'b1, C, 1'b1);
        repeat (4) @(negedge clk_100);
        wait_frames(3, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL b2b_timeout: got %0d bytes, expected 3", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                tests_run++;
                if (got_q[rd_idx] !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", i, got_q[rd_idx], e);
                end
                rd_idx++;
            end
        end
        tests_run++;
        if (ready_cnt - r0 != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_count: got %0d, expected 3", ready_cnt - r0);
        end
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_err: got %0d pulses, expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_glitch();
        int r0, e0, busy_cycles;
        r0 = ready_cnt;
        e0 = err_cnt;
        busy_cycles = 0;
        rx_serial = 1'b0;
        repeat (4) begin
            @(negedge clk_100);
            if (rx_busy) busy_cycles++;
        end
        rx_serial = 1'b1;
        repeat (30) begin
            @(negedge clk_100);
            if (rx_busy) busy_cycles++;
        end
        tests_run++;
        if (busy_cycles < 1 || busy_cycles > 10) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy_cycles: got %0d, expected 1..10", busy_cycles);
        end
        tests_run++;
        if (ready_cnt != r0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_ready: got %0d pulses, expected 0", ready_cnt - r0);
        end
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_frame_err: got %0d pulses, expected 0", err_cnt - e0);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy_end: got %b, expected 0", rx_busy);
        end
    endtask

    task automatic test_frame_error();
        int r0, e0;
        bit ok;
        logic [7:0] e;
        send_frame(8'h11, 1'b1, C, 1'b1);
        repeat (4) @(negedge clk_100);
        wait_frames(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL ferr_first_timeout: got %0d bytes, expected 1", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q[rd_idx] !== e) begin
                tests_failed++;
                $display("[TB] FAIL ferr_first_byte: got %h, expected %h", got_q[rd_idx], e);
            end
            rd_idx++;
        end

        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 40, 1'b0);
        tests_run++;
        if (err_cnt - e0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL ferr_pulse_count: got %0d, expected 1", err_cnt - e0);
        end
        tests_run++;
        if (ready_cnt != r0) begin
            tests_failed++;
            $display("[TB] FAIL ferr_ready: got %0d pulses, expected 0", ready_cnt - r0);
        end
        tests_run++;
        if (rx_byte !== 8'h11) begin
            tests_failed++;
            $display("[TB] FAIL ferr_byte_held: got %h, expected 11", rx_byte);
        end
        tests_run++;
        if (rx_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ferr_break_busy: got %b, expected 1", rx_busy);
        end
        rx_serial = 1'b1;
        repeat (C) @(negedge clk_100);
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ferr_break_exit: got %b, expected 0", rx_busy);
        end

        send_frame(8'h55, 1'b1, C, 1'b1);
        repeat (4) @(negedge clk_100);
        wait_frames(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL ferr_next_timeout: got %0d bytes, expected 1", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q[rd_idx] !== e) begin
                tests_failed++;
                $display("[TB] FAIL ferr_next_byte: got %h, expected %h", got_q[rd_idx], e);
            end
            rd_idx++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, e0;
        bit ok;
        logic [7:0] e;
        r0 = ready_cnt;
        e0 = err_cnt;
        fork
            send_frame(8'hC3, 1'b1, C, 1'b0);
            begin
                // Middle of data bit 4 (start bit plus four data bits in).
                repeat (5 * C + C / 2) @(negedge clk_100);
                Reset_n = 1'b0;
                #1;
                tests_run++;
                if (rx_byte !== 8'h00 || rx_ready !== 1'b0 ||
                    rx_frame_err !== 1'b0 || rx_busy !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL midreset_outputs: got byte=%h rdy=%b ferr=%b busy=%b, expected all 0",
                             rx_byte, rx_ready, rx_frame_err, rx_busy);
                end
                repeat (3) @(negedge clk_100);
                Reset_n = 1'b1;
            end
        join
        repeat (2 * C) @(negedge clk_100);
        tests_run++;
        if (ready_cnt != r0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ready: got %0d pulses, expected 0", ready_cnt - r0);
        end
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_frame_err: got %0d pulses, expected 0", err_cnt - e0);
        end
        rd_idx = got_q.size();

        send_frame(8'h5A, 1'b1, C, 1'b1);
        repeat (4) @(negedge clk_100);
        wait_frames(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next_timeout: got %0d bytes, expected 1", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q[rd_idx] !== e) begin
                tests_failed++;
                $display("[TB] FAIL midreset_next_byte: got %h, expected %h", got_q[rd_idx], e);
            end
            rd_idx++;
        end
    endtask

    task automatic test_latency();
        int  lat;
        bit  found;
        bit  ok;
        logic [7:0] e;
        lat   = -1;
        found = 1'b0;
        fork
            send_frame(8'h01, 1'b1, C, 1'b1);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(posedge clk_100);
                    #1;
                    if (rx_ready) begin
                        found = 1'b1;
                        lat   = k;
                        break;
                    end
                end
            end
        join
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL latency_timeout: got no rx_ready in 400 cycles, expected %0d", LAT_NOM);
        end else if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
            tests_failed++;
            $display("[TB] FAIL latency_cycles: got %0d, expected %0d..%0d", lat, LAT_NOM - 1, LAT_NOM + 1);
        end
        repeat (4) @(negedge clk_100);
        wait_frames(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL latency_byte_timeout: got %0d bytes, expected 1", got_q.size() - rd_idx);
            exp_q.delete();
            rd_idx = got_q.size();
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (got_q[rd_idx] !== e) begin
                tests_failed++;
                $display("[TB] FAIL latency_byte: got %h, expected %h", got_q[rd_idx], e);
            end
            rd_idx++;
        end
    endtask

    task automatic test_pulse_rules();
        tests_run++;
        if (overlap_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL ready_ferr_overlap: got %0d cycles, expected 0", overlap_cnt);
        end
        tests_run++;
        if (long_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL ready_pulse_width: got %0d extra cycles, expected 0", long_cnt);
        end
        tests_run++;
        if (got_q.size() != rd_idx) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_bytes: got %0d extra, expected 0", got_q.size() - rd_idx);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        rx_serial = 1'b1;
        test_reset();
        test_single_frame();
        repeat (C) @(negedge clk_100);
        test_back_to_back();
        repeat (C) @(negedge clk_100);
        test_glitch();
        test_frame_error();
        repeat (C) @(negedge clk_100);
        test_reset_mid_frame();
        repeat (C) @(negedge clk_100);
        test_latency();
        repeat (C) @(negedge clk_100);
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
